// File: rtl/core_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect input and IF/ID output.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 64
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif

interface core_ifu_if;
  logic                       imem_req_valid_o;
  logic                       imem_req_ready_i;
  logic [`CPU_PC_SIZE-1:0]    imem_addr_o;
  logic                       imem_resp_valid_i;
  logic [`CPU_INSTR_SIZE-1:0] imem_rdata_i;
  logic                       redirect_valid_i;
  logic [`CPU_PC_SIZE-1:0]    redirect_pc_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [`CPU_PC_SIZE-1:0]    pc_o;
  logic [`CPU_INSTR_SIZE-1:0] instr_o;
  logic [`CPU_PC_SIZE-1:0]    snpc_o;

  // Fetch unit side.
  modport master (
    output imem_req_valid_o, imem_addr_o, out_valid_o, pc_o, instr_o, snpc_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_rdata_i, redirect_valid_i, redirect_pc_i,
           out_ready_i
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req_valid_o, imem_addr_o, out_valid_o, pc_o, instr_o, snpc_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_rdata_i, redirect_valid_i, redirect_pc_i,
           out_ready_i
  );
endinterface

// File: rtl/core_ifu.sv
// Instruction fetch unit: one outstanding memory request, redirect handling with
// response dropping, and a holding slot toward the IF/ID register.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 64
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif

module core_ifu #(
  parameter logic [`CPU_PC_SIZE-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic        clk,
  input logic        rst,
  core_ifu_if.master bus
);

  localparam int unsigned PcW = `CPU_PC_SIZE;
  localparam int unsigned InW = `CPU_INSTR_SIZE;

  typedef enum logic [1:0] {StReq, StWait, StDrop, StHold} state_e;

  state_e           state_q, state_d;
  logic [PcW-1:0]   pc_q, pc_d;
  logic [InW-1:0]   instr_q, instr_d;
  logic [PcW-1:0]   redirect_tgt;

  // Targets are word aligned; the low two bits of the redirect PC are dropped.
  assign redirect_tgt = {bus.redirect_pc_i[PcW-1:2], 2'b00};

  // State, PC and instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: handshakes, redirects and response dropping.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StReq: begin
        if (bus.redirect_valid_i) begin
          pc_d = redirect_tgt;
          // A request accepted this cycle is stale; its response must be swallowed.
          if (bus.imem_req_ready_i) state_d = StDrop;
        end else if (bus.imem_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.redirect_valid_i) begin
          pc_d    = redirect_tgt;
          state_d = bus.imem_resp_valid_i ? StReq : StDrop;
        end else if (bus.imem_resp_valid_i) begin
          instr_d = bus.imem_rdata_i;
          state_d = StHold;
        end
      end
      StDrop: begin
        if (bus.redirect_valid_i) pc_d = redirect_tgt;
        // Once the stale response has arrived nothing is outstanding, even if a
        // redirect lands in the same cycle, so fetching can resume.
        if (bus.imem_resp_valid_i) state_d = StReq;
      end
      StHold: begin
        if (bus.redirect_valid_i) begin
          pc_d    = redirect_tgt;
          state_d = StReq;
        end else if (bus.out_ready_i) begin
          pc_d    = pc_q + PcW'(4);
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Outputs are decodes of the registered state; requests are masked during reset.
  assign bus.imem_req_valid_o = (state_q == StReq) && !rst;
  assign bus.imem_addr_o      = pc_q;
  assign bus.out_valid_o      = (state_q == StHold);
  assign bus.pc_o             = pc_q;
  assign bus.instr_o          = instr_q;
  assign bus.snpc_o           = pc_q + PcW'(4);

endmodule
